// File: rtl/sva_thread_sched.sv
// Purpose : thread-slot scheduler for SVA checker attempts; sequences one shared
//           next-state evaluator over every active attempt, then a fresh one.
// Latency : IDLE re-entered NUM_SLOTS + k + 2 cycles after accept (k active slots,
//           each ack in its first request cycle); each ack wait cycle adds one.
// Backpressure: smp_ready is high only in IDLE; eval_req and its payload hold
//           until eval_ack is sampled high.
// Ports   : gclk/grst       clock, async active-high reset
//           smp_*           sample handshake (valid/ready) and payload
//           eval_*          evaluator request (req/slot/state/data) and response (ack/next/code)
//           *_pulse         one-cycle event strobes
//           *_cnt           saturating event counters, active slot count
//           busy            scheduler is sequencing a sample
module sva_thread_sched #(
  parameter int NUM_SLOTS   = 4,
  parameter int STATE_W     = 8,
  parameter int DATA_W      = 2,
  parameter int TS_W        = 16,
  parameter int MAX_AGE     = 255,
  parameter int CNT_W       = 16,
  parameter int START_STATE = 0
) (
  input  logic                             gclk,
  input  logic                             grst,
  input  logic                             smp_valid,
  input  logic [DATA_W-1:0]                smp_data,
  output logic                             smp_ready,
  output logic                             eval_req,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   eval_slot,
  output logic [STATE_W-1:0]               eval_state,
  output logic [DATA_W-1:0]                eval_data,
  input  logic                             eval_ack,
  input  logic [STATE_W-1:0]               eval_next,
  input  logic [1:0]                       eval_code,
  output logic                             succ_pulse,
  output logic                             fail_pulse,
  output logic                             timeout_pulse,
  output logic                             overflow_pulse,
  output logic [CNT_W-1:0]                 succ_cnt,
  output logic [CNT_W-1:0]                 fail_cnt,
  output logic [CNT_W-1:0]                 ovf_cnt,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   active_cnt,
  output logic                             busy
);

  localparam int SW = $clog2(NUM_SLOTS + 1);
  localparam logic [SW-1:0]      LAST_IDX  = SW'(NUM_SLOTS - 1);
  localparam logic [SW-1:0]      FRESH_IDX = SW'(NUM_SLOTS);
  localparam logic [TS_W-1:0]    AGE_LIMIT = TS_W'(MAX_AGE);
  localparam logic [STATE_W-1:0] START_ID  = STATE_W'(START_STATE);
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  localparam logic [1:0] CODE_CONT = 2'b00;
  localparam logic [1:0] CODE_SUCC = 2'b01;
  localparam logic [1:0] CODE_FAIL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_SPAWN,
    S_WAIT_SPAWN
  } fsm_t;

  fsm_t                fsm, fsm_nx;
  logic [SW-1:0]       idx, idx_nx;
  logic [TS_W-1:0]     tick, tick_nx;
  logic [NUM_SLOTS-1:0] slot_act, slot_act_nx;
  logic [STATE_W-1:0]  slot_st    [NUM_SLOTS];
  logic [STATE_W-1:0]  slot_st_nx [NUM_SLOTS];
  logic [TS_W-1:0]     slot_ts    [NUM_SLOTS];
  logic [TS_W-1:0]     slot_ts_nx [NUM_SLOTS];

  logic                req_nx;
  logic [SW-1:0]       slot_nx;
  logic [STATE_W-1:0]  state_nx;
  logic [DATA_W-1:0]   data_nx;
  logic                succ_nx, fail_nx, tmo_nx, ovf_nx;
  logic [CNT_W-1:0]    succ_cnt_nx, fail_cnt_nx, ovf_cnt_nx;
  logic [SW-1:0]       act_cnt_nx;

  logic                cur_act;
  logic [STATE_W-1:0]  cur_st;
  logic [TS_W-1:0]     cur_ts;
  logic [TS_W-1:0]     cur_age;
  logic                free_hit;
  logic [SW-1:0]       free_idx;
  logic                ack_take;
  logic                retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  assign smp_ready = (fsm == S_IDLE);
  assign busy      = (fsm != S_IDLE);
  // A response only counts while a request is actually outstanding.
  assign ack_take  = eval_ack & eval_req;
  // Modular subtraction gives the correct age across tick wrap.
  assign cur_age   = tick - cur_ts;

  // View of the slot under idx, and the lowest free slot.
  always_comb begin
    cur_act  = 1'b0;
    cur_st   = '0;
    cur_ts   = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SW'(i) == idx) begin
        cur_act = slot_act[i];
        cur_st  = slot_st[i];
        cur_ts  = slot_ts[i];
      end
    end
    // Descending walk so the last hit is the lowest free index.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_act[i]) begin
        free_hit = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  always_comb begin
    fsm_nx      = fsm;
    idx_nx      = idx;
    tick_nx     = tick;
    data_nx     = eval_data;
    slot_act_nx = slot_act;
    slot_st_nx  = slot_st;
    slot_ts_nx  = slot_ts;
    succ_nx     = 1'b0;
    fail_nx     = 1'b0;
    tmo_nx      = 1'b0;
    ovf_nx      = 1'b0;
    succ_cnt_nx = succ_cnt;
    fail_cnt_nx = fail_cnt;
    ovf_cnt_nx  = ovf_cnt;
    req_nx      = 1'b0;
    slot_nx     = '0;
    state_nx    = '0;
    act_cnt_nx  = '0;
    retire      = 1'b0;

    case (fsm)
      S_IDLE: begin
        if (smp_valid) begin
          data_nx = smp_data;
          tick_nx = tick + TS_W'(1);
          idx_nx  = '0;
          fsm_nx  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (cur_act) begin
          fsm_nx = S_WAIT;
        end else if (idx == LAST_IDX) begin
          fsm_nx = S_SPAWN;
        end else begin
          idx_nx = idx + SW'(1);
        end
      end

      S_WAIT: begin
        if (ack_take) begin
          case (eval_code)
            CODE_CONT: begin
              // Timeout only applies to attempts that would otherwise continue.
              if (cur_age >= AGE_LIMIT) begin
                retire      = 1'b1;
                tmo_nx      = 1'b1;
                fail_cnt_nx = sat_inc(fail_cnt);
              end
            end
            CODE_SUCC: begin
              retire      = 1'b1;
              succ_nx     = 1'b1;
              succ_cnt_nx = sat_inc(succ_cnt);
            end
            CODE_FAIL: begin
              retire      = 1'b1;
              fail_nx     = 1'b1;
              fail_cnt_nx = sat_inc(fail_cnt);
            end
            default: retire = 1'b1;
          endcase
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (SW'(i) == idx) begin
              if (eval_code == CODE_CONT) slot_st_nx[i] = eval_next;
              if (retire) slot_act_nx[i] = 1'b0;
            end
          end
          if (idx == LAST_IDX) begin
            fsm_nx = S_SPAWN;
          end else begin
            idx_nx = idx + SW'(1);
            fsm_nx = S_SCAN;
          end
        end
      end

      S_SPAWN: fsm_nx = S_WAIT_SPAWN;

      S_WAIT_SPAWN: begin
        if (ack_take) begin
          case (eval_code)
            CODE_CONT: begin
              if (free_hit) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (SW'(i) == free_idx) begin
                    slot_act_nx[i] = 1'b1;
                    slot_st_nx[i]  = eval_next;
                    slot_ts_nx[i]  = tick;
                  end
                end
              end else begin
                ovf_nx     = 1'b1;
                ovf_cnt_nx = sat_inc(ovf_cnt);
              end
            end
            CODE_SUCC: begin
              succ_nx     = 1'b1;
              succ_cnt_nx = sat_inc(succ_cnt);
            end
            CODE_FAIL: begin
              fail_nx     = 1'b1;
              fail_cnt_nx = sat_inc(fail_cnt);
            end
            default: ;
          endcase
          fsm_nx = S_IDLE;
        end
      end

      default: fsm_nx = S_IDLE;
    endcase

    // Request outputs are registered, so they are derived from the next state.
    if (fsm_nx == S_WAIT) begin
      req_nx   = 1'b1;
      slot_nx  = idx_nx;
      state_nx = cur_st;
    end else if (fsm_nx == S_WAIT_SPAWN) begin
      req_nx   = 1'b1;
      slot_nx  = FRESH_IDX;
      state_nx = START_ID;
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      act_cnt_nx = act_cnt_nx + SW'(slot_act_nx[i]);
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      fsm            <= S_IDLE;
      idx            <= '0;
      tick           <= '0;
      slot_act       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_st[i] <= '0;
        slot_ts[i] <= '0;
      end
      eval_req       <= 1'b0;
      eval_slot      <= '0;
      eval_state     <= '0;
      eval_data      <= '0;
      succ_pulse     <= 1'b0;
      fail_pulse     <= 1'b0;
      timeout_pulse  <= 1'b0;
      overflow_pulse <= 1'b0;
      succ_cnt       <= '0;
      fail_cnt       <= '0;
      ovf_cnt        <= '0;
      active_cnt     <= '0;
    end else begin
      fsm            <= fsm_nx;
      idx            <= idx_nx;
      tick           <= tick_nx;
      slot_act       <= slot_act_nx;
      slot_st        <= slot_st_nx;
      slot_ts        <= slot_ts_nx;
      eval_req       <= req_nx;
      eval_slot      <= slot_nx;
      eval_state     <= state_nx;
      eval_data      <= data_nx;
      succ_pulse     <= succ_nx;
      fail_pulse     <= fail_nx;
      timeout_pulse  <= tmo_nx;
      overflow_pulse <= ovf_nx;
      succ_cnt       <= succ_cnt_nx;
      fail_cnt       <= fail_cnt_nx;
      ovf_cnt        <= ovf_cnt_nx;
      active_cnt     <= act_cnt_nx;
    end
  end

endmodule

// File: tb/tb_sva_thread_sched.sv
// Directed bench for sva_thread_sched. Instance a uses default parameters,
// instance b uses MAX_AGE = 3; the idle one is held in reset and sel picks
// which instance's outputs are observed.
module tb_sva_thread_sched;

  logic        gclk = 1'b0;
  logic        grst_a, grst_b, sel;
  logic        smp_valid;
  logic [1:0]  smp_data;
  logic        eval_ack;
  logic [7:0]  eval_next;
  logic [1:0]  eval_code;

  logic        a_smp_ready, a_eval_req, a_succ_pulse, a_fail_pulse, a_timeout_pulse, a_overflow_pulse, a_busy;
  logic [2:0]  a_eval_slot, a_active_cnt;
  logic [7:0]  a_eval_state;
  logic [1:0]  a_eval_data;
  logic [15:0] a_succ_cnt, a_fail_cnt, a_ovf_cnt;
  logic        b_smp_ready, b_eval_req, b_succ_pulse, b_fail_pulse, b_timeout_pulse, b_overflow_pulse, b_busy;
  logic [2:0]  b_eval_slot, b_active_cnt;
  logic [7:0]  b_eval_state;
  logic [1:0]  b_eval_data;
  logic [15:0] b_succ_cnt, b_fail_cnt, b_ovf_cnt;

  logic        smp_ready, eval_req, busy;
  logic [2:0]  eval_slot, active_cnt;
  logic [7:0]  eval_state;
  logic [1:0]  eval_data;
  logic [3:0]  pls;  // {succ, fail, timeout, overflow}
  logic [15:0] succ_cnt, fail_cnt, ovf_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ack_cyc = 0;
  logic rdy_post = 1'b0;
  int exp_st [4];

  sva_thread_sched u_a (
    .gclk(gclk), .grst(grst_a),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(a_smp_ready),
    .eval_req(a_eval_req), .eval_slot(a_eval_slot), .eval_state(a_eval_state), .eval_data(a_eval_data),
    .eval_ack(eval_ack), .eval_next(eval_next), .eval_code(eval_code),
    .succ_pulse(a_succ_pulse), .fail_pulse(a_fail_pulse), .timeout_pulse(a_timeout_pulse),
    .overflow_pulse(a_overflow_pulse),
    .succ_cnt(a_succ_cnt), .fail_cnt(a_fail_cnt), .ovf_cnt(a_ovf_cnt),
    .active_cnt(a_active_cnt), .busy(a_busy)
  );

  sva_thread_sched #(.MAX_AGE(3)) u_b (
    .gclk(gclk), .grst(grst_b),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(b_smp_ready),
    .eval_req(b_eval_req), .eval_slot(b_eval_slot), .eval_state(b_eval_state), .eval_data(b_eval_data),
    .eval_ack(eval_ack), .eval_next(eval_next), .eval_code(eval_code),
    .succ_pulse(b_succ_pulse), .fail_pulse(b_fail_pulse), .timeout_pulse(b_timeout_pulse),
    .overflow_pulse(b_overflow_pulse),
    .succ_cnt(b_succ_cnt), .fail_cnt(b_fail_cnt), .ovf_cnt(b_ovf_cnt),
    .active_cnt(b_active_cnt), .busy(b_busy)
  );

  always_comb begin
    if (sel) begin
      smp_ready = b_smp_ready; eval_req = b_eval_req; busy = b_busy;
      eval_slot = b_eval_slot; active_cnt = b_active_cnt;
      eval_state = b_eval_state; eval_data = b_eval_data;
      pls = {b_succ_pulse, b_fail_pulse, b_timeout_pulse, b_overflow_pulse};
      succ_cnt = b_succ_cnt; fail_cnt = b_fail_cnt; ovf_cnt = b_ovf_cnt;
    end else begin
      smp_ready = a_smp_ready; eval_req = a_eval_req; busy = a_busy;
      eval_slot = a_eval_slot; active_cnt = a_active_cnt;
      eval_state = a_eval_state; eval_data = a_eval_data;
      pls = {a_succ_pulse, a_fail_pulse, a_timeout_pulse, a_overflow_pulse};
      succ_cnt = a_succ_cnt; fail_cnt = a_fail_cnt; ovf_cnt = a_ovf_cnt;
    end
  end

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one sample at a negedge; returns at the negedge after the accept edge.
  task automatic send_sample(input int d);
    int n = 0;
    while (smp_ready !== 1'b1 && n < 60) begin
      @(negedge gclk);
      n++;
    end
    check("ready_before_accept", 32'(smp_ready), 1);
    smp_valid = 1'b1;
    smp_data  = 2'(d);
    @(negedge gclk);
    smp_valid = 1'b0;
    acc_cyc   = cyc;
    check("busy_after_accept", 32'(busy), 1);
  endtask

  // Wait for a request, check its payload, optionally hold off the ack, then
  // respond and check the strobes in the following cycle and the one after.
  task automatic respond(input int es, input int est, input int ed, input int code,
                         input int nxt, input int ep, input int dly);
    int n = 0;
    while (eval_req !== 1'b1 && n < 60) begin
      @(negedge gclk);
      n++;
    end
    check("req_seen", 32'(eval_req), 1);
    check("eval_slot", 32'(eval_slot), 32'(es));
    check("eval_state", 32'(eval_state), 32'(est));
    check("eval_data", 32'(eval_data), 32'(ed));
    for (int d = 0; d < dly; d++) begin
      @(negedge gclk);
      check("req_held", 32'(eval_req), 1);
      check("slot_held", 32'(eval_slot), 32'(es));
    end
    eval_ack  = 1'b1;
    eval_code = 2'(code);
    eval_next = 8'(nxt);
    @(negedge gclk);
    eval_ack  = 1'b0;
    eval_code = 2'b00;
    eval_next = 8'h00;
    ack_cyc   = cyc;
    rdy_post  = smp_ready;
    check("req_drop", 32'(eval_req), 0);
    check("pulses", 32'(pls), 32'(ep));
    @(negedge gclk);
    check("pulses_clear", 32'(pls), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; grst_a = 1'b1; grst_b = 1'b1;
    smp_valid = 1'b0; smp_data = 2'b00;
    eval_ack = 1'b0; eval_next = 8'h00; eval_code = 2'b00;
    repeat (3) @(negedge gclk);

    // Reset state
    check("rst_ready", 32'(smp_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_active", 32'(active_cnt), 0);
    check("rst_succ_cnt", 32'(succ_cnt), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 0);
    check("rst_req", 32'(eval_req), 0);
    check("rst_slot", 32'(eval_slot), 0);
    check("rst_pulses", 32'(pls), 0);
    grst_a = 1'b0;
    @(negedge gclk);
    check("idle_ready", 32'(smp_ready), 1);

    // First sample: spawn continues into slot 0 with state 1
    send_sample(1);
    respond(4, 0, 1, 0, 'h01, 0, 0);
    check("first_latency", 32'(ack_cyc - acc_cyc), 6);
    check("first_idle", 32'(rdy_post), 1);
    check("first_active", 32'(active_cnt), 1);

    // Success on slot 0, spawn reuses slot 0 after a two-cycle ack delay
    send_sample(2);
    respond(0, 1, 2, 1, 'h00, 8, 0);
    check("succ_cnt_1", 32'(succ_cnt), 1);
    check("succ_active", 32'(active_cnt), 0);
    respond(4, 0, 2, 0, 'h05, 0, 2);
    check("reuse_latency", 32'(ack_cyc - acc_cyc), 9);
    check("reuse_active", 32'(active_cnt), 1);

    // Fail on slot 0 (state 5 proves the reuse), vacuous spawn
    send_sample(3);
    respond(0, 5, 3, 2, 'h00, 4, 0);
    check("fail_cnt_1", 32'(fail_cnt), 1);
    check("fail_active", 32'(active_cnt), 0);
    respond(4, 0, 3, 3, 'h00, 0, 0);
    check("drop_active", 32'(active_cnt), 0);
    check("drop_latency", 32'(ack_cyc - acc_cyc), 7);

    // Overflow: five samples, all continue, fifth spawn has no free slot
    for (int s = 0; s < 5; s++) begin
      send_sample(s % 4);
      for (int i = 0; i < s; i++) begin
        respond(i, exp_st[i], s % 4, 0, exp_st[i] + 1, 0, 0);
        exp_st[i] = exp_st[i] + 1;
      end
      respond(4, 0, s % 4, 0, 16 * (s + 1), (s == 4) ? 1 : 0, 0);
      if (s < 4) exp_st[s] = 16 * (s + 1);
      check("ovf_active", 32'(active_cnt), (s < 4) ? 32'(s + 1) : 32'd4);
    end
    check("ovf_cnt_1", 32'(ovf_cnt), 1);
    check("full_latency", 32'(ack_cyc - acc_cyc), 10);
    check("ovf_succ_cnt", 32'(succ_cnt), 1);

    // Reset while a request is outstanding with the ack withheld
    send_sample(2);
    begin
      int n = 0;
      while (eval_req !== 1'b1 && n < 60) begin
        @(negedge gclk);
        n++;
      end
    end
    check("mid_req", 32'(eval_req), 1);
    check("mid_slot", 32'(eval_slot), 0);
    check("mid_state", 32'(eval_state), 32'(exp_st[0]));
    repeat (2) @(negedge gclk);
    check("mid_req_held", 32'(eval_req), 1);
    grst_a = 1'b1;
    #1;
    check("mid_rst_req", 32'(eval_req), 0);
    check("mid_rst_active", 32'(active_cnt), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(smp_ready), 1);
    check("mid_rst_ovf_cnt", 32'(ovf_cnt), 0);
    check("mid_rst_fail_cnt", 32'(fail_cnt), 0);
    @(negedge gclk);
    grst_a = 1'b0;
    // A stray ack while idle must be ignored
    eval_ack = 1'b1; eval_code = 2'b01;
    @(negedge gclk);
    eval_ack = 1'b0; eval_code = 2'b00;
    @(negedge gclk);
    check("stray_ack_pulses", 32'(pls), 0);
    check("stray_ack_succ_cnt", 32'(succ_cnt), 0);
    check("stray_ack_busy", 32'(busy), 0);
    send_sample(3);
    respond(4, 0, 3, 3, 'h00, 0, 0);
    check("post_rst_latency", 32'(ack_cyc - acc_cyc), 6);
    check("post_rst_active", 32'(active_cnt), 0);

    // Timeout on instance b (MAX_AGE = 3)
    grst_a = 1'b1;
    sel = 1'b1;
    @(negedge gclk);
    grst_b = 1'b0;
    @(negedge gclk);
    check("b_rst_ready", 32'(smp_ready), 1);
    check("b_rst_active", 32'(active_cnt), 0);
    send_sample(0);
    respond(4, 0, 0, 0, 'h01, 0, 0);
    send_sample(1);
    respond(0, 1, 1, 0, 'h02, 0, 0);
    respond(4, 0, 1, 3, 'h00, 0, 0);
    send_sample(2);
    respond(0, 2, 2, 0, 'h03, 0, 0);
    respond(4, 0, 2, 3, 'h00, 0, 0);
    send_sample(3);
    respond(0, 3, 3, 0, 'h04, 2, 0);
    check("tmo_fail_cnt", 32'(fail_cnt), 1);
    check("tmo_active", 32'(active_cnt), 0);
    // The freed slot is reused by the spawn of the same sample
    respond(4, 0, 3, 0, 'h09, 0, 0);
    check("tmo_reuse_active", 32'(active_cnt), 1);
    send_sample(0);
    respond(0, 9, 0, 0, 'h0a, 0, 0);
    respond(4, 0, 0, 3, 'h00, 0, 0);
    send_sample(1);
    respond(0, 10, 1, 0, 'h0b, 0, 0);
    respond(4, 0, 1, 3, 'h00, 0, 0);
    // Age has reached the limit, but success wins over timeout
    send_sample(2);
    respond(0, 11, 2, 1, 'h00, 8, 0);
    check("prec_fail_cnt", 32'(fail_cnt), 1);
    check("prec_succ_cnt", 32'(succ_cnt), 1);
    check("prec_active", 32'(active_cnt), 0);
    respond(4, 0, 2, 3, 'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sva_thread_sched.md
# sva_thread_sched

Thread-slot scheduler for the SVA checker FSM datapath. It owns a pool of `NUM_SLOTS` concurrent assertion attempts. Each attempt is a state id plus a start timestamp. For every accepted sample it sequences one shared external next-state evaluator over all active attempts, then over a fresh attempt. It retires attempts on success, failure or timeout, and keeps event counters. It sits between the sampled-signal stage and the per-property next-state evaluator, in the assertion clock domain.

## Interface
Parameters:
- `NUM_SLOTS`, 4 — number of concurrent attempt slots (≥1)
- `STATE_W`, 8 — evaluator state id width
- `DATA_W`, 2 — sample payload width (sampled property signals)
- `TS_W`, 16 — tick/timestamp width
- `MAX_AGE`, 255 — timeout age in ticks; must be < 2^TS_W
- `CNT_W`, 16 — event counter width
- `START_STATE`, 0 — state id of a fresh attempt

Ports:
- `gclk`  in  1  clock
- `grst`  in  1  reset, asynchronous, active-high
- `smp_valid`  in  1  sample offered
- `smp_data`  in  `DATA_W`  sample payload
- `smp_ready`  out  1  scheduler idle; sample accepted when valid&ready
- `eval_req`  out  1  evaluation request
- `eval_slot`  out  `$clog2(NUM_SLOTS+1)`  slot index; `NUM_SLOTS` marks a fresh attempt
- `eval_state`  out  `STATE_W`  current state of the attempt
- `eval_data`  out  `DATA_W`  latched sample
- `eval_ack`  in  1  evaluator response valid
- `eval_next`  in  `STATE_W`  next state
- `eval_code`  in  2  response code: 00 continue, 01 success, 10 fail, 11 drop (vacuous)
- `succ_pulse`, `fail_pulse`, `timeout_pulse`, `overflow_pulse`  out  1 each  one-cycle event strobes
- `succ_cnt`, `fail_cnt`, `ovf_cnt`  out  `CNT_W` each  saturating counters; `fail_cnt` includes timeouts
- `active_cnt`  out  `$clog2(NUM_SLOTS+1)`  number of occupied slots
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- Slot fields: `active`, `state[STATE_W]`, `start_ts[TS_W]`.
- `tick`: TS_W counter incremented on each accept; wraps modulo 2^TS_W.
- Age of an attempt = `(tick - start_ts) mod 2^TS_W`.

States: IDLE, SCAN, WAIT, SPAWN, WAIT_SPAWN.
- **IDLE**
  - `smp_ready` = 1.
  - On `smp_valid`: latch `smp_data`, increment `tick`, set `idx` = 0, go to SCAN.
- **SCAN**
  - If `slot[idx]` is active: go to WAIT.
  - Else increment `idx`.
  - After the last index, go to SPAWN.
- **WAIT**
  - `eval_req` = 1 with `eval_slot` = `idx`, `eval_state` = `slot.state`.
  - On `eval_ack`:
    - continue: `slot.state` ← `eval_next`. If age ≥ `MAX_AGE`, free the slot, `timeout_pulse`, increment `fail_cnt`.
    - success: free the slot, `succ_pulse`, increment `succ_cnt`.
    - fail: free the slot, `fail_pulse`, increment `fail_cnt`.
    - drop: free the slot silently.
  - Then increment `idx` and return to SCAN, or go to SPAWN after the last slot.
- **SPAWN**: go to WAIT_SPAWN.
- **WAIT_SPAWN**
  - `eval_req` = 1 with `eval_slot` = `NUM_SLOTS`, `eval_state` = `START_STATE`.
  - On ack with continue: allocate the lowest-index free slot with `state` = `eval_next`, `start_ts` = `tick`. If no slot is free: `overflow_pulse`, increment `ovf_cnt`, discard the attempt.
  - success/fail/drop: handled as in WAIT; no slot is allocated.
  - Then go to IDLE.

Ordering and precedence:
- Existing attempts are evaluated in ascending slot order before the fresh attempt.
- A slot freed during the scan is available to the spawn of the same sample.
- A success or fail code takes precedence over timeout.

## Timing
- Reset values: all slots inactive; `tick` = 0; state IDLE.
- Output reset values: `smp_ready` = 1, `busy` = 0, `eval_req` = 0, `eval_slot`/`eval_state`/`eval_data` = 0, all pulses = 0, all counters = 0.
- All outputs except `smp_ready` and `busy` are registered.
- Handshake:
  - `eval_req` and its payload are held stable until `eval_ack` is sampled high.
  - `eval_req` deasserts on the following edge.
  - `eval_ack` while `eval_req` = 0 is ignored.
- Event pulses are high for exactly one cycle, in the cycle after the acking edge.
- Counters update on the same edge as their pulse.
- Counters saturate at 2^`CNT_W`−1; the pulses still fire.
- Latency, with k active slots and ack in the first WAIT cycle: IDLE is re-entered `NUM_SLOTS + k + 2` cycles after the accept edge.
- Each additional ack wait cycle adds one cycle.
- `grst` mid-operation: immediately drops `eval_req` and the pulses, clears all slots and counters, and returns to IDLE. The in-flight response is lost.

## Test plan
Default parameters, except where noted.
1. **Reset**: assert `grst` → `smp_ready` = 1, `busy` = 0, `active_cnt` = 0, all counters 0, `eval_req` = 0.
2. **First sample**: one sample, spawn acked with continue, `eval_next` = 1 → `active_cnt` = 1, slot 0 state 1, `smp_ready` back 6 cycles after accept (k = 0).
3. **Success and reuse**: second sample → request with `eval_slot` = 0, `eval_state` = 1; ack success → `succ_pulse`, `succ_cnt` = 1. Spawn continue then reuses slot 0.
4. **Overflow**: five samples, every response continue → fifth spawn gives `overflow_pulse`, `ovf_cnt` = 1, `active_cnt` = 4.
5. **Timeout**: `MAX_AGE` = 3; attempt spawned at sample 1, continue on samples 2–4 → `timeout_pulse` on sample 4, `fail_cnt` = 1, slot freed.
6. **Reset mid-evaluation**: assert `grst` during WAIT with ack withheld → `eval_req` low immediately, `active_cnt` = 0. After release, the next sample scans zero active slots.
